// File: rtl/if_fetch_if.sv
// Bundles the fetch stage's memory-read handshake, decode-side instruction
// handshake and redirect inputs. The fetch stage is the master.
interface if_fetch_if;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [7:0]  mem_data_i;
    logic        inst_valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    modport master (
        input  stall_i,
        input  branch_i,
        input  branch_target_i,
        input  mem_ack_i,
        input  mem_data_i,
        output mem_req_o,
        output mem_addr_o,
        output inst_valid_o,
        output pc_o,
        output inst_o
    );

    modport slave (
        output stall_i,
        output branch_i,
        output branch_target_i,
        output mem_ack_i,
        output mem_data_i,
        input  mem_req_o,
        input  mem_addr_o,
        input  inst_valid_o,
        input  pc_o,
        input  inst_o
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Each 32-bit instruction is gathered as four byte
// reads (little-endian) from a byte-wide memory controller, then held for
// decode under a valid/stall handshake. A branch redirect from ex overrides
// everything except reset. All outputs come straight from registers.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_if.master bus
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_VALID = 1'b1
    } state_e;

    state_e      state_q;
    logic [31:0] fetch_pc_q;
    logic [1:0]  cnt_q;
    logic [23:0] buf_q;
    logic        mem_req_q;
    logic [31:0] mem_addr_q;
    logic        inst_valid_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;

    logic [31:0] cur_byte_addr_d;
    logic [31:0] next_byte_addr_d;
    logic [31:0] next_pc_d;
    logic [23:0] buf_d;

    // Address arithmetic and the buffer with the returned byte merged into lane cnt.
    always_comb begin
        cur_byte_addr_d  = fetch_pc_q + {30'd0, cnt_q};
        next_byte_addr_d = fetch_pc_q + {30'd0, cnt_q} + 32'd1;
        next_pc_d        = fetch_pc_q + 32'd4;
        buf_d            = buf_q;
        case (cnt_q)
            2'd0:    buf_d[7:0]   = bus.mem_data_i;
            2'd1:    buf_d[15:8]  = bus.mem_data_i;
            2'd2:    buf_d[23:16] = bus.mem_data_i;
            default: buf_d        = buf_q;
        endcase
    end

    // Fetch FSM: reset, branch redirect, byte gathering and decode handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_FETCH;
            fetch_pc_q   <= RESET_PC;
            cnt_q        <= 2'd0;
            buf_q        <= 24'd0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= RESET_PC;
            inst_valid_q <= 1'b0;
            pc_q         <= 32'd0;
            inst_q       <= 32'd0;
        end else if (bus.branch_i) begin
            // Redirect wins: any partial word or pending instruction is dropped,
            // and an ack arriving in this cycle belongs to the abandoned fetch.
            state_q      <= ST_FETCH;
            fetch_pc_q   <= bus.branch_target_i;
            cnt_q        <= 2'd0;
            mem_req_q    <= 1'b1;
            mem_addr_q   <= bus.branch_target_i;
            inst_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!mem_req_q) begin
                        // First cycle after reset: raise the request; any ack
                        // seen now has no request behind it and is ignored.
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= cur_byte_addr_d;
                    end else if (bus.mem_ack_i) begin
                        if (cnt_q == 2'd3) begin
                            inst_q       <= {bus.mem_data_i, buf_q};
                            pc_q         <= fetch_pc_q;
                            inst_valid_q <= 1'b1;
                            mem_req_q    <= 1'b0;
                            cnt_q        <= 2'd0;
                            state_q      <= ST_VALID;
                        end else begin
                            buf_q      <= buf_d;
                            cnt_q      <= cnt_q + 2'd1;
                            mem_addr_q <= next_byte_addr_d;
                        end
                    end else begin
                        // Waiting on the controller: address must stay stable.
                        mem_addr_q <= mem_addr_q;
                    end
                end
                ST_VALID: begin
                    if (!bus.stall_i) begin
                        inst_valid_q <= 1'b0;
                        fetch_pc_q   <= next_pc_d;
                        mem_req_q    <= 1'b1;
                        mem_addr_q   <= next_pc_d;
                        state_q      <= ST_FETCH;
                    end else begin
                        // Decode is stalled: hold the presented instruction.
                        inst_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_FETCH;
                    cnt_q        <= 2'd0;
                    inst_valid_q <= 1'b0;
                    mem_req_q    <= 1'b1;
                    mem_addr_q   <= fetch_pc_q;
                end
            endcase
        end
    end

    assign bus.mem_req_o    = mem_req_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.inst_valid_o = inst_valid_q;
    assign bus.pc_o         = pc_q;
    assign bus.inst_o       = inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a per-cycle vector table for the basic fetch,
// consume and stall behaviour, then hand-written sequences for delayed acks,
// branch redirects, mid-fetch reset and address wrap.
module tb_if_fetch;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        stall;
        logic        ack;
        logic [7:0]  data;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vt[15];

    // Simple memory image for the hand-written sequences.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return (a[7:0] ^ a[15:8] ^ a[31:24]) + 8'h3C;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic branch, input logic [31:0] target,
                         input logic ack, input logic [7:0] data);
        bus.stall_i         = stall;
        bus.branch_i        = branch;
        bus.branch_target_i = target;
        bus.mem_ack_i       = ack;
        bus.mem_data_i      = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Gather one word at base with 'dly' idle cycles before each ack.
    // Entry precondition: mem_req_o=1 and mem_addr_o=base.
    task automatic fetch_word(input logic [31:0] base, input int dly);
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < dly; w++) begin
                drive(1'b0, 1'b0, 32'd0, 1'b0, 8'h00);
                step();
                check("wait_req", {31'd0, bus.mem_req_o}, 32'd1);
                check("wait_addr_stable", bus.mem_addr_o, base + k);
            end
            drive(1'b0, 1'b0, 32'd0, 1'b1, mem_byte(base + k));
            step();
            if (k < 3) begin
                check("byte_addr", bus.mem_addr_o, base + k + 1);
                check("byte_valid", {31'd0, bus.inst_valid_o}, 32'd0);
            end
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 8'h00);
        check("word_valid", {31'd0, bus.inst_valid_o}, 32'd1);
        check("word_req", {31'd0, bus.mem_req_o}, 32'd0);
        check("word_pc", bus.pc_o, base);
        check("word_inst", bus.inst_o, mem_word(base));
    endtask

    initial begin
        // {stall, ack, data} applied before the edge; outputs expected after it.
        vt[0]  = '{1'b0, 1'b1, 8'hEE, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0};
        vt[1]  = '{1'b0, 1'b1, 8'h13, 1'b1, 32'd1, 1'b0, 32'd0, 32'd0};
        vt[2]  = '{1'b0, 1'b1, 8'h05, 1'b1, 32'd2, 1'b0, 32'd0, 32'd0};
        vt[3]  = '{1'b0, 1'b1, 8'h50, 1'b1, 32'd3, 1'b0, 32'd0, 32'd0};
        vt[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 32'd0, 1'b1, 32'd0, 32'h0050_0513};
        vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 32'd4, 1'b0, 32'd0, 32'd0};
        vt[6]  = '{1'b0, 1'b1, 8'h93, 1'b1, 32'd5, 1'b0, 32'd0, 32'd0};
        vt[7]  = '{1'b0, 1'b1, 8'h00, 1'b1, 32'd6, 1'b0, 32'd0, 32'd0};
        vt[8]  = '{1'b0, 1'b1, 8'h10, 1'b1, 32'd7, 1'b0, 32'd0, 32'd0};
        vt[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 32'd0, 1'b1, 32'd4, 32'h0010_0093};
        vt[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 32'd0, 1'b1, 32'd4, 32'h0010_0093};
        vt[11] = '{1'b1, 1'b1, 8'hFF, 1'b0, 32'd0, 1'b1, 32'd4, 32'h0010_0093};
        vt[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 32'd0, 1'b1, 32'd4, 32'h0010_0093};
        vt[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 32'd0, 1'b1, 32'd4, 32'h0010_0093};
        vt[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 32'd8, 1'b0, 32'd0, 32'd0};

        drive(1'b0, 1'b0, 32'd0, 1'b0, 8'h00);
        rst = 1'b0;
        step();
        step();
        check("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
        check("rst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        check("rst_pc", bus.pc_o, 32'd0);
        check("rst_inst", bus.inst_o, 32'd0);
        check("rst_addr", bus.mem_addr_o, 32'd0);

        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].stall, 1'b0, 32'd0, vt[i].ack, vt[i].data);
            step();
            check($sformatf("vec%0d_req", i), {31'd0, bus.mem_req_o}, {31'd0, vt[i].e_req});
            check($sformatf("vec%0d_valid", i), {31'd0, bus.inst_valid_o}, {31'd0, vt[i].e_valid});
            if (vt[i].e_req) begin
                check($sformatf("vec%0d_addr", i), bus.mem_addr_o, vt[i].e_addr);
            end
            if (vt[i].e_valid) begin
                check($sformatf("vec%0d_pc", i), bus.pc_o, vt[i].e_pc);
                check($sformatf("vec%0d_inst", i), bus.inst_o, vt[i].e_inst);
            end
        end

        // Acks delayed three cycles each at address 8.
        fetch_word(32'd8, 3);

        // Consume, collect two bytes at 12, then branch with a same-cycle ack.
        drive(1'b0, 1'b0, 32'd0, 1'b0, 8'h00);
        step();
        check("consume_addr", bus.mem_addr_o, 32'd12);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 8'hA1);
        step();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 8'hA2);
        step();
        check("pre_branch_addr", bus.mem_addr_o, 32'd14);
        drive(1'b0, 1'b1, 32'h0000_1000, 1'b1, 8'hAA);
        step();
        check("branch_addr", bus.mem_addr_o, 32'h0000_1000);
        check("branch_req", {31'd0, bus.mem_req_o}, 32'd1);
        check("branch_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        fetch_word(32'h0000_1000, 0);

        // Branch while an instruction is valid and not stalled: it is dropped.
        drive(1'b0, 1'b1, 32'h0000_2000, 1'b0, 8'h00);
        step();
        check("bvalid_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        check("bvalid_addr", bus.mem_addr_o, 32'h0000_2000);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 8'h00);
        step();
        check("bvalid_no_old_pc", bus.mem_addr_o, 32'h0000_2000);

        // Two bytes in (cnt=2), then reset with an ack present.
        drive(1'b0, 1'b0, 32'd0, 1'b1, 8'h11);
        step();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 8'h22);
        step();
        check("prerst_addr", bus.mem_addr_o, 32'h0000_2002);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b1, 8'h33);
        step();
        check("midrst_req", {31'd0, bus.mem_req_o}, 32'd0);
        check("midrst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        check("midrst_pc", bus.pc_o, 32'd0);
        check("midrst_inst", bus.inst_o, 32'd0);
        check("midrst_addr", bus.mem_addr_o, 32'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 8'h00);
        step();
        check("rel_req", {31'd0, bus.mem_req_o}, 32'd1);
        check("rel_addr", bus.mem_addr_o, 32'd0);
        fetch_word(32'd0, 1);

        // Address wrap at the top of the space.
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 8'h00);
        step();
        check("wrap_branch_addr", bus.mem_addr_o, 32'hFFFF_FFFC);
        fetch_word(32'hFFFF_FFFC, 0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 8'h00);
        step();
        check("wrap_next_addr", bus.mem_addr_o, 32'd0);
        check("wrap_next_req", {31'd0, bus.mem_req_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage: the producer of the `pc`/`inst` pair that decode consumes.
- Reads each 32-bit instruction as four byte reads from the byte-wide memory controller and assembles them little-endian.
- Presents the instruction to if_id with a valid/stall handshake and redirects on branch/jump from ex.
- Sits between the memory controller and the if_id pipeline register.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- stall_i  input  1  downstream cannot accept an instruction this cycle.
- branch_i  input  1  redirect request from ex (one-cycle pulse).
- branch_target_i  input  32  redirect address, sampled when branch_i=1.
- mem_req_o  output  1  byte read request to memory controller.
- mem_addr_o  output  32  byte address; stable while mem_req_o=1 until ack.
- mem_ack_i  input  1  byte read complete; mem_data_i valid this cycle.
- mem_data_i  input  8  returned byte.
- inst_valid_o  output  1  pc_o/inst_o hold a complete instruction.
- pc_o  output  32  address of inst_o.
- inst_o  output  32  assembled instruction.

Behaviour:
- Reset, when rst=0 at a clock edge:
  - Registered outputs: mem_req_o=0, inst_valid_o=0, pc_o=0, inst_o=0, mem_addr_o=RESET_PC.
  - Internal state: fetch_pc=RESET_PC, byte count=0, state=FETCH.
  - Any fetch in progress is abandoned and its partial bytes discarded.
- All outputs are registered; no combinational input-to-output paths.
- FETCH state:
  - mem_req_o=1 and mem_addr_o=fetch_pc+cnt, where cnt is 0..3 (2-bit counter).
  - On mem_ack_i, store mem_data_i into byte cnt of the buffer: cnt=0 goes to [7:0], cnt=3 goes to [31:24].
  - After an ack with cnt<3: cnt increments and mem_addr_o advances by 1 at the next edge.
  - On the ack with cnt=3: the next edge loads inst_o (full word), pc_o=fetch_pc, inst_valid_o=1, mem_req_o=0, cnt=0, and moves to VALID.
  - mem_ack_i may arrive in any cycle with mem_req_o=1, including the first; mem_ack_i while mem_req_o=0 is ignored.
  - stall_i has no effect in FETCH; fetch proceeds regardless.
- VALID state:
  - If stall_i=0, the instruction is consumed at this edge: inst_valid_o→0, fetch_pc→fetch_pc+4, state→FETCH, mem_req_o→1 with mem_addr_o=new fetch_pc.
  - If stall_i=1, inst_valid_o, pc_o and inst_o hold unchanged for as many cycles as the stall lasts.
- Throughput: with zero-wait acks, one instruction every 5 cycles (4 request cycles plus 1 valid cycle).
- Address arithmetic is modulo 2^32, so fetch_pc=32'hFFFFFFFC advances to 0.
- Branch redirect (highest priority, any state except reset):
  - When branch_i=1, at the next edge fetch_pc=branch_target_i, cnt=0, inst_valid_o=0, state=FETCH, mem_req_o=1, mem_addr_o=branch_target_i.
  - A mem_ack_i in the branch cycle is discarded.
  - A pending VALID instruction is dropped even if stall_i=0 in that cycle; downstream must not latch an instruction in a branch cycle.
  - branch_target_i is used unmodified; no alignment check.
- Reset has priority over branch_i.

Test Plan:
- Reset release, memory bytes at 0..3 = 13,05,50,00 with ack every cycle → mem_addr_o 0,1,2,3 in consecutive cycles; next cycle inst_valid_o=1, pc_o=0, inst_o=32'h00500513; following request at addr 4.
- Acks delayed 3 cycles each → mem_addr_o stays stable until each ack; inst_o still assembles correctly.
- stall_i=1 for 4 cycles while inst_valid_o=1 → pc_o/inst_o/inst_valid_o unchanged for all 4 cycles; mem_req_o=0; fetch of pc+4 starts the cycle after stall_i falls.
- branch_i=1 with target 32'h00001000 after 2 of 4 byte acks (and an ack in the same cycle) → next cycle mem_addr_o=32'h1000, cnt restarts; delivered instruction has pc_o=32'h1000 built from bytes 0x1000..0x1003 only.
- branch_i=1 while inst_valid_o=1 and stall_i=0 → inst_valid_o=0 next cycle; no fetch at old pc+4.
- rst=0 mid-fetch (cnt=2) → all outputs take reset values next edge; after release, fetch restarts at RESET_PC with cnt=0.
